// File: rtl/sifh_hist_arbiter.sv
// sifh_hist_arbiter
// Shares one dual-port histogram RAM between NPIX pixel TDC streams.
// The RAM is first cleared. Hits are then granted round-robin, one per cycle.
// Each granted hit runs a read-increment-write pipeline with hazard forwarding.
// On stop the pipeline is drained and done pulses for one cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, outputs quiet
// ST_CLEAR | writing zero to every RAM word, one word per cycle
// ST_ACC   | granting hits round-robin, pipeline running
// ST_DRAIN | no new grants, three cycles so the last write is presented
// ST_DONE  | one-cycle done pulse, then back to idle
module sifh_hist_arbiter #(
  parameter  int NPIX_W = 2,
  parameter  int NB     = 6,
  parameter  int CW     = 8,
  localparam int NPIX   = 1 << NPIX_W,
  localparam int AW     = NPIX_W + NB
) (
  input  logic                 clk_i,
  input  logic                 res_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [NPIX-1:0]      req_i,
  input  logic [NPIX*NB-1:0]   bin_i,
  output logic [NPIX-1:0]      gnt_o,
  output logic [AW-1:0]        raddr_o,
  output logic                 rEnable_o,
  output logic                 readFlag_o,
  input  logic [CW-1:0]        counts_i,
  output logic [AW-1:0]        waddr_o,
  output logic                 wEnable_o,
  output logic                 writeFlag_o,
  output logic [CW-1:0]        newCounts_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sat_o,
  output logic [23:0]          hit_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [NPIX_W-1:0]   rr_q;
  logic [1:0]          drain_q;

  // read stage (t+1): drives RAM port B
  logic                s1_v_q;
  logic [AW-1:0]       raddr_q;
  // compute stage (t+2): RAM data arrives
  logic                s2_v_q;
  logic [AW-1:0]       s2_addr_q;
  // write stage (t+3): drives RAM port A, also used by the clear sweep
  logic                w_v_q;
  logic [AW-1:0]       waddr_q;
  logic [CW-1:0]       wdata_q;
  // copy of the write presented one cycle earlier, for forwarding
  logic                pw_v_q;
  logic [AW-1:0]       pw_addr_q;
  logic [CW-1:0]       pw_data_q;

  logic                sat_q;
  logic [23:0]         hit_cnt_q;
  logic                busy_q;
  logic                done_q;

  logic                hit;
  logic [NPIX_W-1:0]   gnt_idx;
  logic [NPIX_W-1:0]   cand;
  logic [NB-1:0]       gnt_bin;
  logic [CW-1:0]       base;
  logic                at_max;
  logic [CW-1:0]       result;

  // Round-robin search upward from the pixel after the last one granted.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == ST_ACC && !stop_i) begin
      for (int i = 1; i <= NPIX; i++) begin
        cand = rr_q + NPIX_W'(i);
        if (!hit && req_i[cand]) begin
          hit     = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt_bin = bin_i[int'(gnt_idx)*NB +: NB];
  assign gnt_o   = hit ? (NPIX'(1) << gnt_idx) : '0;

  // Pick the freshest value for the bin in the compute stage.
  // The RAM is read-first, so the two most recent writes may not be in counts_i yet.
  always_comb begin
    base = counts_i;
    if (w_v_q && (waddr_q == s2_addr_q)) begin
      base = wdata_q;
    end else if (pw_v_q && (pw_addr_q == s2_addr_q)) begin
      base = pw_data_q;
    end
    at_max = &base;
    result = at_max ? base : base + CW'(1);
  end

  // State machine, pipeline registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      drain_q   <= '0;
      s1_v_q    <= 1'b0;
      raddr_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_addr_q <= '0;
      w_v_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pw_v_q    <= 1'b0;
      pw_addr_q <= '0;
      pw_data_q <= '0;
      sat_q     <= 1'b0;
      hit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pw_v_q    <= w_v_q;
      pw_addr_q <= waddr_q;
      pw_data_q <= wdata_q;

      s1_v_q <= hit;
      if (hit) begin
        raddr_q   <= {gnt_idx, gnt_bin};
        hit_cnt_q <= hit_cnt_q + 24'd1;
      end

      s2_v_q    <= s1_v_q;
      s2_addr_q <= raddr_q;

      w_v_q <= s2_v_q;
      if (s2_v_q) begin
        waddr_q <= s2_addr_q;
        wdata_q <= result;
        if (at_max) begin
          sat_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_CLEAR;
            busy_q    <= 1'b1;
            sat_q     <= 1'b0;
            hit_cnt_q <= '0;
            rr_q      <= NPIX_W'(NPIX - 1);
            w_v_q     <= 1'b1;
            waddr_q   <= '0;
            wdata_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (waddr_q == {AW{1'b1}}) begin
            state_q <= ST_ACC;
            w_v_q   <= 1'b0;
          end else begin
            w_v_q   <= 1'b1;
            waddr_q <= waddr_q + AW'(1);
            wdata_q <= '0;
          end
        end
        ST_ACC: begin
          if (stop_i) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end else if (hit) begin
            rr_q <= gnt_idx;
          end
        end
        ST_DRAIN: begin
          if (drain_q == 2'd2) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign raddr_o     = raddr_q;
  assign rEnable_o   = s1_v_q;
  assign readFlag_o  = s1_v_q;
  assign waddr_o     = waddr_q;
  assign wEnable_o   = w_v_q;
  assign writeFlag_o = w_v_q;
  assign newCounts_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sat_o       = sat_q;
  assign hit_cnt_o   = hit_cnt_q;

endmodule

// File: tb/tb_sifh_hist_arbiter.sv
// Bench for sifh_hist_arbiter: a behavioural histogram model predicts every
// cycle's grant, RAM traffic and status, and is compared against the DUT.
module tb_sifh_hist_arbiter;

  localparam int NPIX_W = 2;
  localparam int NB     = 6;
  localparam int CW     = 8;
  localparam int NPIX   = 1 << NPIX_W;
  localparam int AW     = NPIX_W + NB;
  localparam int DEPTH  = 1 << AW;
  localparam int CMAX   = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                res, start, stop;
  logic [NPIX-1:0]     req;
  logic [NPIX*NB-1:0]  bin;
  logic [NPIX-1:0]     gnt;
  logic [AW-1:0]       raddr, waddr;
  logic                rEnable, readFlag, wEnable, writeFlag;
  logic [CW-1:0]       counts, newCounts;
  logic                busy, done, sat;
  logic [23:0]         hit_cnt;

  sifh_hist_arbiter #(.NPIX_W(NPIX_W), .NB(NB), .CW(CW)) dut (
    .clk_i(clk), .res_i(res), .start_i(start), .stop_i(stop),
    .req_i(req), .bin_i(bin), .gnt_o(gnt),
    .raddr_o(raddr), .rEnable_o(rEnable), .readFlag_o(readFlag),
    .counts_i(counts),
    .waddr_o(waddr), .wEnable_o(wEnable), .writeFlag_o(writeFlag),
    .newCounts_o(newCounts),
    .busy_o(busy), .done_o(done), .sat_o(sat), .hit_cnt_o(hit_cnt)
  );

  always #5 clk = ~clk;

  // read-first RAM with one cycle read latency
  logic [CW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rEnable && readFlag) counts <= mem[raddr];
    if (wEnable && writeFlag) mem[waddr] <= newCounts;
  end

  // reference model
  typedef struct { int cyc; int addr; int val; bit satf; } wr_t;
  typedef struct { int cyc; int addr; } rd_t;
  wr_t         wq[$];
  rd_t         rq[$];
  int          m_ph;      // 0 idle, 1 clear, 2 acc, 3 drain, 4 done
  int          m_clr, m_drain, m_rr;
  int          hist[DEPTH];
  logic [23:0] m_hits;
  bit          m_sat;
  int          cyc;

  int n_vec = 0;
  int n_err = 0;

  bit pend[NPIX];
  int pbin[NPIX];
  int last_g;
  int ndone, done_cyc, stop_cyc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_req();
    for (int p = 0; p < NPIX; p++) begin
      req[p] = pend[p];
      bin[p*NB +: NB] = NB'(pbin[p]);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model, move past the rising edge.
  task automatic step();
    int eg, a;
    logic [31:0] emask;
    bit ew, er;
    int ewa, ewd, era;
    wr_t w;
    rd_t r;
    @(negedge clk);
    eg = -1;
    if (m_ph == 2 && !stop) begin
      for (int k = 1; k <= NPIX; k++) begin
        if (eg < 0 && req[(m_rr + k) % NPIX]) eg = (m_rr + k) % NPIX;
      end
    end
    emask = (eg < 0) ? 32'd0 : (32'd1 << eg);
    chk_eq("gnt", 32'(gnt), emask);

    ew = 0; ewa = 0; ewd = 0;
    if (m_ph == 1) begin
      ew = 1; ewa = m_clr; ewd = 0;
    end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
      w = wq.pop_front();
      ew = 1; ewa = w.addr; ewd = w.val;
      if (w.satf) m_sat = 1;
    end
    chk_eq("wEnable", 32'(wEnable), 32'(ew));
    chk_eq("writeFlag", 32'(writeFlag), 32'(ew));
    if (ew) begin
      chk_eq("waddr", 32'(waddr), ewa);
      chk_eq("newCounts", 32'(newCounts), ewd);
    end

    er = 0; era = 0;
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      er = 1; era = r.addr;
    end
    chk_eq("rEnable", 32'(rEnable), 32'(er));
    chk_eq("readFlag", 32'(readFlag), 32'(er));
    if (er) chk_eq("raddr", 32'(raddr), era);

    chk_eq("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= 3));
    chk_eq("done", 32'(done), 32'(m_ph == 4));
    chk_eq("sat", 32'(sat), 32'(m_sat));
    chk_eq("hit_cnt", 32'(hit_cnt), 32'(m_hits));
    if (done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
    end

    last_g = -1;
    if (!res) begin
      m_ph = 0; wq.delete(); rq.delete(); m_hits = 0; m_sat = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_ph = 1; m_clr = 0; m_hits = 0; m_sat = 0; m_rr = NPIX - 1;
          for (int i = 0; i < DEPTH; i++) hist[i] = 0;
        end
        1: if (m_clr == DEPTH - 1) m_ph = 2; else m_clr++;
        2: if (stop) begin
          m_ph = 3; m_drain = 0;
        end else if (eg >= 0) begin
          a = eg * (1 << NB) + pbin[eg];
          w.satf = (hist[a] == CMAX);
          if (hist[a] < CMAX) hist[a]++;
          w.cyc = cyc + 3; w.addr = a; w.val = hist[a];
          wq.push_back(w);
          r.cyc = cyc + 1; r.addr = a;
          rq.push_back(r);
          m_hits = m_hits + 24'd1;
          m_rr = eg;
          last_g = eg;
        end
        3: begin
          m_drain++;
          if (m_drain == 3) m_ph = 4;
        end
        default: m_ph = 0;
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pend();
    for (int p = 0; p < NPIX; p++) pend[p] = 0;
    drive_req();
  endtask

  task automatic rand_traffic(input int ncyc, input bit hazards);
    for (int n = 0; n < ncyc; n++) begin
      for (int p = 0; p < NPIX; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1;
          pbin[p] = hazards ? int'($urandom_range(0, 3)) : int'($urandom_range(0, (1 << NB) - 1));
        end
      end
      start = ($urandom_range(0, 31) == 0);
      drive_req();
      step();
      start = 0;
      if (last_g >= 0) pend[last_g] = 0;
    end
  endtask

  task automatic chk_mem();
    for (int a = 0; a < DEPTH; a++) chk_eq($sformatf("mem[%0d]", a), 32'(mem[a]), hist[a]);
  endtask

  task automatic do_start(input bit with_stop);
    start = 1; stop = with_stop;
    step();
    start = 0; stop = 0;
    for (int i = 0; i < DEPTH; i++) step();
  endtask

  // one hit accepted the cycle before stop, then drain and wait for done
  task automatic end_run();
    clear_pend();
    pend[2] = 1; pbin[2] = int'($urandom_range(0, (1 << NB) - 1));
    drive_req();
    step();
    for (int p = 0; p < NPIX; p++) pend[p] = 1;
    drive_req();
    stop = 1; stop_cyc = cyc;
    step();
    stop = 0;
    clear_pend();
    ndone = 0; done_cyc = -100;
    for (int i = 0; i < 10; i++) step();
    chk_eq("done_pulses", ndone, 1);
    chk_eq("stop_to_done", done_cyc - stop_cyc, 4);
    chk_mem();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 0; start = 0; stop = 0; req = '0; bin = '0;
    m_ph = 0; m_clr = 0; m_drain = 0; m_rr = 0; m_hits = 0; m_sat = 0; cyc = 0;
    for (int i = 0; i < DEPTH; i++) begin hist[i] = 0; mem[i] = '0; end
    for (int p = 0; p < NPIX; p++) begin pend[p] = 0; pbin[p] = 0; end
    repeat (3) step();
    res = 1;

    stop = 1; step(); stop = 0; step();

    do_start(1'b0);

    // pixel 1, bin 5, three back-to-back hits
    pend[1] = 1; pbin[1] = 5; drive_req();
    repeat (3) step();
    clear_pend();
    repeat (4) step();
    chk_eq("dir_hit_cnt", 32'(hit_cnt), 3);
    chk_eq("dir_mem69", 32'(mem[69]), 3);

    // all four pixels requesting
    for (int p = 0; p < NPIX; p++) begin pend[p] = 1; pbin[p] = p * 3 + 1; end
    drive_req();
    repeat (8) step();
    clear_pend();
    repeat (4) step();

    rand_traffic(300, 1'b1);
    rand_traffic(200, 1'b0);
    end_run();

    // saturation on pixel 0 bin 0; start and stop together
    do_start(1'b1);
    pend[0] = 1; pbin[0] = 0; drive_req();
    repeat (CMAX + 2) step();
    clear_pend();
    repeat (4) step();
    chk_eq("sat_hit_cnt", 32'(hit_cnt), CMAX + 2);
    chk_eq("sat_flag", 32'(sat), 1);
    chk_eq("sat_mem0", 32'(mem[0]), CMAX);
    end_run();

    // reset in the middle of accumulation
    do_start(1'b0);
    rand_traffic(40, 1'b1);
    res = 0;
    step();
    res = 1;
    clear_pend();
    step();
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_hit_cnt", 32'(hit_cnt), 0);

    do_start(1'b0);
    rand_traffic(150, 1'b1);
    end_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sifh_hist_arbiter.md
Name: sifh_hist_arbiter

Overview:
Shares one dual-port histogram RAM between NPIX pixel TDC streams for the SiFH dToF histogrammer. Each pixel owns a 2^NB-bin slice at RAM address {pixel, bin}. The block first clears the RAM, then grants one hit per cycle round-robin and runs a pipelined read-increment-write with hazard forwarding. On stop it drains the pipeline and pulses done, after which the peak-find stage takes over.

Parameters:
NPIX_W, 2, pixel index width; NPIX = 2^NPIX_W requesters
NB, 6, bin address width per pixel
CW, 8, histogram count width (peakMax)
AW, NPIX_W+NB, RAM address width (derived, not overridable)

Ports:
clk  in  1  clock
res  in  1  synchronous active-low reset
start  in  1  pulse; begin clear + accumulate (ignored unless IDLE)
stop  in  1  pulse; end accumulation (ignored unless ACC)
req  in  NPIX  per-pixel hit valid
bin  in  NPIX*NB  per-pixel bin index; pixel p at [p*NB +: NB]
gnt  out  NPIX  one-hot grant; hit accepted when req[p]&gnt[p]
raddr  out  AW  RAM port B address
rEnable  out  1  port B enable
readFlag  out  1  port B memory enable
counts  in  CW  port B read data, 1-cycle latency
waddr  out  AW  RAM port A address
wEnable  out  1  port A write enable
writeFlag  out  1  port A memory enable
newCounts  out  CW  port A write data
busy  out  1  high from CLEAR through DRAIN
done  out  1  one-cycle pulse at end of DRAIN
sat  out  1  sticky; some bin saturated this run
hit_cnt  out  24  accepted hits this run, wraps at 2^24

Behaviour:
- Reset (res=0 at a clk edge): state IDLE; all outputs 0, including gnt, sat and hit_cnt; pipeline valids cleared. A reset mid-run abandons any in-flight write.
- States: IDLE, CLEAR, ACC, DRAIN, DONE. All RAM-side outputs are registered. gnt is combinational from state, req and the rr pointer.
- IDLE: start=1 -> CLEAR. Entering CLEAR zeroes sat, hit_cnt and the clear counter, and sets rr pointer = NPIX-1.
- CLEAR: one write per cycle: waddr = 0..2^AW-1, newCounts = 0, wEnable = writeFlag = 1. rEnable = 0. gnt = 0. The cycle after the write to 2^AW-1 is presented -> ACC.
- ACC: gnt = the first p with req[p]=1, searching upward from rr+1 modulo NPIX. At most one grant per cycle. rr <= granted p. If stop=1, gnt = 0 that cycle and the next state is DRAIN.
- Pipeline for a hit accepted in cycle t:
  - t+1: raddr = {p, bin_p}; rEnable = readFlag = 1.
  - t+2: counts valid; compute.
  - t+3: waddr = same address; newCounts = result; wEnable = writeFlag = 1.
  - hit_cnt increments in cycle t+1.
  - Read/write enables are 0 in cycles with no valid stage.
- Hazard forwarding in the compute stage, base value chosen by priority:
  1. the write presented this cycle (current waddr/newCounts) if valid and the address matches;
  2. else the write presented the previous cycle if valid and the address matches;
  3. else counts.
  - Required so back-to-back hits to one bin count correctly. The RAM is treated as read-first.
- Arithmetic: result = base + 1, saturating at 2^CW-1. When base = 2^CW-1, result stays 2^CW-1 and sat is set (sticky until next start).
- DRAIN: no grants. Stays 3 cycles so the last accepted hit's write is presented, then -> DONE.
- DONE: done = 1 for one cycle, busy = 0 -> IDLE.
- busy = 1 in CLEAR, ACC and DRAIN; 0 otherwise.
- start outside IDLE and stop outside ACC have no effect. start and stop together in IDLE: start wins.
- Bins are never dropped: a requester holds req and bin until granted.

Test Plan:
- Reset, then start (NPIX_W=2, NB=6) -> 256 consecutive writes, waddr 0..255, newCounts 0, gnt=0 throughout; ACC on the next cycle; busy=1, sat=0.
- Pixel 1 holds req with bin=5 for 3 accepted hits back-to-back -> writes to waddr 69 with newCounts 1, 2, 3 (forwarding exercised); hit_cnt=3.
- All four req held high for 8 cycles in ACC -> gnt sequence 0001, 0010, 0100, 1000, repeated; writes land at {p, bin_p}.
- CW=4, 17 hits to pixel 0 bin 0 -> newCounts reaches 15 on hit 15 and stays 15 on hits 16 and 17; sat=1 from hit 16's write cycle.
- stop asserted with one hit accepted in the prior cycle -> gnt=0 from the stop cycle onward; that hit's write appears during DRAIN; done pulses once 4 cycles after stop; busy falls with done.
- res=0 in the middle of ACC with hits in flight -> next cycle all outputs 0 and state IDLE; a new start re-clears all 256 bins.
